// File: rtl/qarma128_pkg.sv
// Shared QARMA-128 types, constants and cell-level helper functions.
package qarma128_pkg;

  localparam int unsigned CELL_W = 8;
  localparam int unsigned CELLS  = 16;
  localparam int unsigned RC_NUM = 16;

  typedef logic [CELL_W-1:0] cell_t;
  // Index 15 is cell 0 (the MSB cell); index i holds cell 15-i.
  typedef cell_t [CELLS-1:0] state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fwd_state_e;

  // 4-bit sigma, nibble n at bits [63-4n -: 4]; the 8-bit S-box applies it to both nibbles.
  localparam logic [63:0] SIGMA = 64'h0E2A_9F8B_6437_DC15;

  // Cells touched by the tweak LFSR; bit (15-c) selects cell c.
  localparam logic [15:0] TK_LFSR_CELLS = 16'hD894;

  function automatic logic [3:0] sigma_nib(input logic [3:0] n);
    return 4'(SIGMA >> {4'd15 - n, 2'b00});
  endfunction

  function automatic cell_t sbox_fn(input cell_t x);
    return {sigma_nib(x[7:4]), sigma_nib(x[3:0])};
  endfunction

  function automatic logic [255:0][7:0] gen_sbox();
    logic [255:0][7:0] t;
    for (int i = 0; i < 256; i++) t[8'(i)] = sbox_fn(8'(i));
    return t;
  endfunction

  // Round constants: RC[0] is zero, RC[i] replicates i*0x9E3779B9 (mod 2^32) four times.
  function automatic logic [RC_NUM-1:0][127:0] gen_rc();
    logic [RC_NUM-1:0][127:0] t;
    logic [31:0]              w;
    for (int i = 0; i < RC_NUM; i++) begin
      w          = 32'(i) * 32'h9E37_79B9;
      t[4'(i)]   = {w, w, w, w};
    end
    return t;
  endfunction

  localparam logic [255:0][7:0]        SBOX = gen_sbox();
  localparam logic [RC_NUM-1:0][127:0] RC   = gen_rc();

  // One step of the 8-bit cell LFSR: shift left, feedback x7^x5 into bit 0.
  function automatic cell_t lfsr_cell(input cell_t x);
    return {x[6:0], x[7] ^ x[5]};
  endfunction

  // omega: clock the LFSR on the selected tweak cells only.
  function automatic state_t omega(input state_t s);
    state_t t;
    t = s;
    for (int i = 0; i < 16; i++) begin
      if (TK_LFSR_CELLS[4'(i)]) t[4'(i)] = lfsr_cell(s[4'(i)]);
    end
    return t;
  endfunction

endpackage

// File: rtl/qarma128_mix_columns.sv
// MixColumns with circulant matrix circ(0, rho^a, rho^b, rho^c); rho rotates a cell left by one bit.
module qarma128_mix_columns
  import qarma128_pkg::*;
#(
  parameter logic [11:0] MC_ABC = 12'b0
) (
  input  state_t state,
  output state_t mixed
);

  localparam logic [2:0] ROT_A = MC_ABC[10:8];
  localparam logic [2:0] ROT_B = MC_ABC[6:4];
  localparam logic [2:0] ROT_C = MC_ABC[2:0];

  function automatic cell_t rotl(input cell_t x, input logic [2:0] k);
    return (x << k) | (x >> (4'd8 - 4'(k)));
  endfunction

  // Row r of the output mixes rows r+1, r+2, r+3 of the same column.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar col = 0; col < 4; col++) begin : g_col
      assign mixed[4'(15-(4*r+col))] =
          rotl(state[4'(15-(4*((r+1)%4)+col))], ROT_A) ^
          rotl(state[4'(15-(4*((r+2)%4)+col))], ROT_B) ^
          rotl(state[4'(15-(4*((r+3)%4)+col))], ROT_C);
    end
  end

endmodule

// File: rtl/qarma128_shuffle_cells.sv
// Cell permutation: output cell c takes input cell PERM[c] (4-bit indices, cell 0 in PERM[63:60]).
module qarma128_shuffle_cells
  import qarma128_pkg::*;
#(
  parameter logic [63:0] PERM = 64'b0
) (
  input  state_t state,
  output state_t shuffled
);

  for (genvar c = 0; c < 16; c++) begin : g_cell
    localparam logic [3:0] SRC = PERM[63-4*c -: 4];
    assign shuffled[4'(15-c)] = state[4'd15 - SRC];
  end

endmodule

// File: rtl/qarma128_sub_cells.sv
// SubCells: 16 parallel S-box lookups, purely combinational.
module qarma128_sub_cells
  import qarma128_pkg::*;
(
  input  state_t state,
  output state_t subbed
);

  for (genvar c = 0; c < 16; c++) begin : g_cell
    assign subbed[4'(c)] = SBOX[state[4'(c)]];
  end

endmodule

// File: rtl/qarma128_fwd_rounds_iter.sv
// Iterative QARMA-128 forward-round engine, one round per cycle, valid/ready on both sides.
// Optional feature: define QARMA_FWD_FLUSH_EN to add a `flush` input that aborts RUN/DONE.
module qarma128_fwd_rounds_iter
  import qarma128_pkg::*;
#(
  parameter int unsigned N      = 128,
  parameter int unsigned R      = 8,
  parameter logic [63:0] TAU    = 64'b0,
  parameter logic [63:0] H_PERM = 64'b0,
  parameter logic [11:0] MC_ABC = 12'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [N-1:0] in_tk,
  input  logic [N-1:0] in_k0,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef QARMA_FWD_FLUSH_EN
  input  logic         flush,
`endif
  output logic [N-1:0] out_data,
  output logic [N-1:0] out_tk
);

  localparam logic [3:0] LAST = 4'(R - 1);

  fwd_state_e state;
  logic [3:0] cnt;
  state_t     st, tk, k0;
  state_t     x0, shuffled, mixed, x, subbed, tk_shuffled, tk_next;

  // Round datapath: key/tweak/constant addition, full rounds add ShuffleCells+MixColumns.
  assign x0 = st ^ k0 ^ tk ^ RC[cnt];

  qarma128_shuffle_cells #(.PERM(TAU)) u_tau (
    .state    (x0),
    .shuffled (shuffled)
  );

  qarma128_mix_columns #(.MC_ABC(MC_ABC)) u_mc (
    .state (shuffled),
    .mixed (mixed)
  );

  assign x = (cnt == 4'd0) ? x0 : mixed;

  qarma128_sub_cells u_sub (
    .state  (x),
    .subbed (subbed)
  );

  // Tweak schedule: permute with h, then clock the cell LFSRs.
  qarma128_shuffle_cells #(.PERM(H_PERM)) u_h (
    .state    (tk),
    .shuffled (tk_shuffled)
  );

  assign tk_next = omega(tk_shuffled);

  assign out_data = st;
  assign out_tk   = tk;

  // Control FSM and data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      st        <= '0;
      tk        <= '0;
      k0        <= '0;
    end else begin
`ifdef QARMA_FWD_FLUSH_EN
      if (flush && (state != S_IDLE)) begin
        state     <= S_IDLE;
        out_valid <= 1'b0;
        in_ready  <= 1'b1;
      end else
`endif
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            state    <= S_RUN;
            in_ready <= 1'b0;
            st       <= in_data;
            tk       <= in_tk;
            k0       <= in_k0;
            cnt      <= '0;
          end
        end
        S_RUN: begin
          st  <= subbed;
          tk  <= tk_next;
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qarma128_fwd_rounds_iter.sv
// Self-checking bench for qarma128_fwd_rounds_iter (R=8 and R=1 instances).
// Flush scenario is exercised when QARMA_FWD_FLUSH_EN is defined.
module tb_qarma128_fwd_rounds_iter;

  localparam logic [63:0] TAU_P = 64'h0B6D_A1C7_5E38_F492;
  localparam logic [63:0] H_P   = 64'h65EF_0123_7CD4_89AB;
  localparam logic [11:0] MC_P  = 12'h145;
  localparam int SIG [16]       = '{0, 14, 2, 10, 9, 15, 8, 11, 6, 4, 3, 7, 13, 12, 1, 5};
  localparam int LFSR_CELLS [7] = '{0, 1, 3, 4, 8, 11, 13};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         iv, ir, ov, ordy;
  logic [127:0] id, it, ik, od, ot;
  logic         iv1, ir1, ov1, ordy1;
  logic [127:0] id1, it1, ik1, od1, ot1;
`ifdef QARMA_FWD_FLUSH_EN
  logic         flush8;
`endif

  int n_err = 0;
  int n_chk = 0;

  qarma128_fwd_rounds_iter #(
    .N(128), .R(8), .TAU(TAU_P), .H_PERM(H_P), .MC_ABC(MC_P)
  ) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv),
    .in_ready  (ir),
    .in_data   (id),
    .in_tk     (it),
    .in_k0     (ik),
    .out_valid (ov),
    .out_ready (ordy),
`ifdef QARMA_FWD_FLUSH_EN
    .flush     (flush8),
`endif
    .out_data  (od),
    .out_tk    (ot)
  );

  qarma128_fwd_rounds_iter #(
    .N(128), .R(1), .TAU(TAU_P), .H_PERM(H_P), .MC_ABC(MC_P)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv1),
    .in_ready  (ir1),
    .in_data   (id1),
    .in_tk     (it1),
    .in_k0     (ik1),
    .out_valid (ov1),
    .out_ready (ordy1),
`ifdef QARMA_FWD_FLUSH_EN
    .flush     (1'b0),
`endif
    .out_data  (od1),
    .out_tk    (ot1)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] getc(input logic [127:0] v, input int c);
    return 8'(v >> (120 - 8*c));
  endfunction

  function automatic logic [127:0] setc(input logic [127:0] v, input int c, input logic [7:0] b);
    logic [127:0] m;
    m = 128'hFF << (120 - 8*c);
    return (v & ~m) | (128'(b) << (120 - 8*c));
  endfunction

  function automatic logic [127:0] m_perm(input logic [127:0] v, input logic [63:0] p);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 16; c++) r = setc(r, c, getc(v, int'(4'(p >> (60 - 4*c)))));
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    int t;
    n = n % 8;
    t = int'(b);
    t = ((t << n) | (t >> (8 - n))) & 255;
    return 8'(t);
  endfunction

  // Matrix product with circ(0, rho^a, rho^b, rho^c) on the 4x4 cell matrix.
  function automatic logic [127:0] m_mix(input logic [127:0] v);
    logic [127:0] r;
    logic [7:0]   acc;
    int           amt [4];
    int           d;
    amt[0] = 0;
    amt[1] = int'(MC_P[11:8]);
    amt[2] = int'(MC_P[7:4]);
    amt[3] = int'(MC_P[3:0]);
    r = '0;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          d = (j - row + 4) % 4;
          if (d != 0) acc = acc ^ rotl(getc(v, 4*j + col), amt[d]);
        end
        r = setc(r, 4*row + col, acc);
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] b);
    return 8'((SIG[int'(b[7:4])] << 4) | SIG[int'(b[3:0])]);
  endfunction

  function automatic logic [127:0] m_sub(input logic [127:0] v);
    logic [127:0] r;
    r = v;
    for (int c = 0; c < 16; c++) r = setc(r, c, m_sbox(getc(v, c)));
    return r;
  endfunction

  function automatic logic [127:0] m_omega(input logic [127:0] v);
    logic [127:0] r;
    int           x;
    r = v;
    for (int i = 0; i < 7; i++) begin
      x = int'(getc(v, LFSR_CELLS[i]));
      x = ((x << 1) | (((x >> 7) ^ (x >> 5)) & 1)) & 255;
      r = setc(r, LFSR_CELLS[i], 8'(x));
    end
    return r;
  endfunction

  function automatic logic [127:0] m_rc(input int i);
    logic [31:0] w;
    w = 32'(i) * 32'h9E37_79B9;
    return {w, w, w, w};
  endfunction

  function automatic void model(input logic [127:0] d, input logic [127:0] t,
                                input logic [127:0] k, input int rounds,
                                output logic [127:0] o_d, output logic [127:0] o_t);
    logic [127:0] s, w, x;
    s = d;
    w = t;
    for (int i = 0; i < rounds; i++) begin
      x = s ^ k ^ w ^ m_rc(i);
      if (i > 0) x = m_mix(m_perm(x, TAU_P));
      s = m_sub(x);
      w = m_omega(m_perm(w, H_P));
    end
    o_d = s;
    o_t = w;
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full operation on the R=8 engine, optionally stalling the output side.
  task automatic do_op(input string tag, input logic [127:0] d, input logic [127:0] t,
                       input logic [127:0] k, input int stall);
    logic [127:0] ed, et;
    int           lat;
    model(d, t, k, 8, ed, et);
    id = d; it = t; ik = k; iv = 1'b1; ordy = 1'b0;
    @(negedge clk);
    iv = 1'b0; id = rnd(); it = rnd(); ik = rnd();
    check({tag, ".busy_ready"}, 128'(ir), 128'(1'b0));
    lat = 0;
    while (ov !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 128'(lat), 128'(8));
    check({tag, ".data"}, od, ed);
    check({tag, ".tk"}, ot, et);
    for (int s = 0; s < stall; s++) begin
      iv = 1'b1; id = rnd(); it = rnd(); ik = rnd();
      @(negedge clk);
    end
    if (stall > 0) begin
      check({tag, ".hold_valid"}, 128'(ov), 128'(1'b1));
      check({tag, ".hold_data"}, od, ed);
      check({tag, ".hold_tk"}, ot, et);
      check({tag, ".hold_ready"}, 128'(ir), 128'(1'b0));
    end
    iv = 1'b0; ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    check({tag, ".after_valid"}, 128'(ov), 128'(1'b0));
    check({tag, ".after_ready"}, 128'(ir), 128'(1'b1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] ea, ta, eb, tb_, a_d, a_t, a_k, b_d, b_t, b_k;
    int           lat, spur;

    rst_n = 1'b0;
    iv = 1'b0; ordy = 1'b0; id = '0; it = '0; ik = '0;
    iv1 = 1'b0; ordy1 = 1'b0; id1 = '0; it1 = '0; ik1 = '0;
`ifdef QARMA_FWD_FLUSH_EN
    flush8 = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    check("rst.valid", 128'(ov), 128'(1'b0));
    check("rst.ready", 128'(ir), 128'(1'b1));
    check("rst.data", od, 128'd0);
    check("rst.tk", ot, 128'd0);
    check("rst1.valid", 128'(ov1), 128'(1'b0));
    check("rst1.ready", 128'(ir1), 128'(1'b1));
    rst_n = 1'b1;
    @(negedge clk);

    // R=1 short round on all-zero inputs, then on random inputs
    for (int n = 0; n < 2; n++) begin
      if (n == 0) begin a_d = '0; a_t = '0; a_k = '0; end
      else begin a_d = rnd(); a_t = rnd(); a_k = rnd(); end
      model(a_d, a_t, a_k, 1, ea, ta);
      id1 = a_d; it1 = a_t; ik1 = a_k; iv1 = 1'b1;
      @(negedge clk);
      iv1 = 1'b0;
      check("r1.early_valid", 128'(ov1), 128'(1'b0));
      @(negedge clk);
      check("r1.valid", 128'(ov1), 128'(1'b1));
      check("r1.data", od1, ea);
      check("r1.tk", ot1, ta);
      ordy1 = 1'b1;
      @(negedge clk);
      ordy1 = 1'b0;
      check("r1.after_valid", 128'(ov1), 128'(1'b0));
    end

    // R=8 random vectors, with and without short stalls
    for (int n = 0; n < 4; n++) begin
      do_op("rand", rnd(), rnd(), rnd(), (n == 3) ? int'($urandom_range(1, 3)) : 0);
    end

    // Long backpressure with in_valid asserted while busy
    do_op("stall20", rnd(), rnd(), rnd(), 20);

    // Back-to-back requests with out_ready held high
    a_d = rnd(); a_t = rnd(); a_k = rnd();
    b_d = rnd(); b_t = rnd(); b_k = rnd();
    model(a_d, a_t, a_k, 8, ea, ta);
    model(b_d, b_t, b_k, 8, eb, tb_);
    ordy = 1'b1; iv = 1'b1; id = a_d; it = a_t; ik = a_k;
    @(negedge clk);
    id = b_d; it = b_t; ik = b_k;
    lat = 0;
    while (ov !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b.a_latency", 128'(lat), 128'(8));
    check("b2b.a_data", od, ea);
    check("b2b.a_tk", ot, ta);
    @(negedge clk);
    check("b2b.handshake_valid", 128'(ov), 128'(1'b0));
    check("b2b.handshake_ready", 128'(ir), 128'(1'b1));
    @(negedge clk);
    check("b2b.b_accepted", 128'(ir), 128'(1'b0));
    iv = 1'b0;
    lat = 0;
    while (ov !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b.b_latency", 128'(lat), 128'(8));
    check("b2b.b_data", od, eb);
    check("b2b.b_tk", ot, tb_);
    @(negedge clk);
    ordy = 1'b0;
    check("b2b.end_valid", 128'(ov), 128'(1'b0));

    // Reset during round 3
    id = rnd(); it = rnd(); ik = rnd(); iv = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst.valid", 128'(ov), 128'(1'b0));
    check("midrst.ready", 128'(ir), 128'(1'b1));
    check("midrst.data", od, 128'd0);
    check("midrst.tk", ot, 128'd0);
    ordy = 1'b1;
    spur = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ov !== 1'b0) spur++;
    end
    ordy = 1'b0;
    check("midrst.spurious", 128'(spur), 128'(0));

`ifdef QARMA_FWD_FLUSH_EN
    // Flush at round 5: back to IDLE, data regs keep the partial state
    a_d = rnd(); a_t = rnd(); a_k = rnd();
    model(a_d, a_t, a_k, 5, ea, ta);
    id = a_d; it = a_t; ik = a_k; iv = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    repeat (5) @(negedge clk);
    flush8 = 1'b1;
    @(negedge clk);
    flush8 = 1'b0;
    check("flush.valid", 128'(ov), 128'(1'b0));
    check("flush.ready", 128'(ir), 128'(1'b1));
    check("flush.data_kept", od, ea);
    check("flush.tk_kept", ot, ta);
    spur = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ov !== 1'b0) spur++;
    end
    check("flush.spurious", 128'(spur), 128'(0));
    do_op("post_flush", rnd(), rnd(), rnd(), 0);
`endif

    // Engine still healthy after the disruptions
    do_op("final", rnd(), rnd(), rnd(), 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
